// File: rtl/serial_word_tx_if.sv
// Word-in / serial-out bundle for serial_word_tx.
// A word transfers on a rising clk edge where word_valid && word_ready; word_ready is
// registered and reflects FIFO occupancy before that edge; the master may hold word_valid.
interface serial_word_tx_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] word_in;
  logic             word_valid;
  logic             word_ready;
  logic             dataout;
  logic             com_en;
  logic             busy;
  logic [CNT_W-1:0] fifo_count;
  logic             state_dbg;

  modport master (
    output word_in, word_valid,
    input  word_ready, dataout, com_en, busy, fifo_count, state_dbg
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, dataout, com_en, busy, fifo_count, state_dbg
  );
endinterface

// File: rtl/serial_word_tx.sv
// FIFO-buffered word serialiser with frame-enable strobe and clock-enable bit timing.
// Optional even-parity trailer bit when SER_TX_PARITY_EN is defined.
module serial_word_tx #(
  parameter int WIDTH     = 32,
  parameter int DIV       = 50,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  serial_word_tx_if.slave  bus
);

`ifdef SER_TX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = $clog2(NB + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dataout_q, dataout_d;
  logic             com_en_q, com_en_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
`ifdef SER_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             push;
  logic             pop;
  logic [BIT_W-1:0] bit_nxt;

  // Bit idx of the frame in transmit order, taken from the data word.
  function automatic logic data_bit(input logic [WIDTH-1:0] w, input logic [BIT_W-1:0] idx);
    logic [WIDTH-1:0] sh;
    if (MSB_FIRST != 0) begin
      sh = w << idx;
      return sh[WIDTH-1];
    end else begin
      sh = w >> idx;
      return sh[0];
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    word_d    = word_q;
    dataout_d = dataout_q;
    com_en_d  = com_en_q;
`ifdef SER_TX_PARITY_EN
    par_d     = par_q;
`endif
    pop       = 1'b0;
    push      = bus.word_valid && ready_q;
    bit_nxt   = bit_q + BIT_W'(1);

    case (state_q)
      IDLE: begin
        dataout_d = 1'b0;
        com_en_d  = 1'b0;
        if (count_q != '0) begin
          pop       = 1'b1;
          word_d    = mem_q[rd_ptr_q];
          bit_d     = '0;
          tick_d    = '0;
          state_d   = SHIFT;
          com_en_d  = 1'b1;
          dataout_d = data_bit(mem_q[rd_ptr_q], '0);
`ifdef SER_TX_PARITY_EN
          par_d     = ^mem_q[rd_ptr_q];
`endif
        end
      end
      SHIFT: begin
        // With DIV=1 the compare value is 0, so every cycle ends a bit.
        if (tick_q == TICK_W'(DIV - 1)) begin
          tick_d = '0;
          if (bit_q == BIT_W'(NB - 1)) begin
            state_d   = IDLE;
            bit_d     = '0;
            com_en_d  = 1'b0;
            dataout_d = 1'b0;
          end else begin
            bit_d = bit_nxt;
`ifdef SER_TX_PARITY_EN
            if (bit_nxt == BIT_W'(WIDTH)) begin
              dataout_d = par_q;
            end else begin
              dataout_d = data_bit(word_q, bit_nxt);
            end
`else
            dataout_d = data_bit(word_q, bit_nxt);
`endif
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        com_en_d  = 1'b0;
        dataout_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Registered ready: a pop on the full edge cannot admit a push on that same edge.
    ready_d = (count_d != CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      word_q    <= '0;
      dataout_q <= 1'b0;
      com_en_q  <= 1'b0;
      ready_q   <= 1'b0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
`ifdef SER_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      word_q    <= word_d;
      dataout_q <= dataout_d;
      com_en_q  <= com_en_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
`ifdef SER_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.word_in;
    end
  end

  assign bus.word_ready = ready_q;
  assign bus.dataout    = dataout_q;
  assign bus.com_en     = com_en_q;
  assign bus.busy       = (state_q == SHIFT) || (count_q != '0);
  assign bus.fifo_count = count_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: three instances (MSB/DIV4, LSB/DIV4, MSB/DIV1).
// Expected frames are queued at stimulus time and checked by a negedge monitor.
module tb_serial_word_tx;
`ifdef SER_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  serial_word_tx_if #(.WIDTH(8), .DEPTH(4)) if0 ();
  serial_word_tx_if #(.WIDTH(8), .DEPTH(4)) if1 ();
  serial_word_tx_if #(.WIDTH(8), .DEPTH(4)) if2 ();

  serial_word_tx #(.WIDTH(8), .DIV(4), .DEPTH(4), .MSB_FIRST(1)) u_msb (.clk(clk), .rst(rst), .bus(if0));
  serial_word_tx #(.WIDTH(8), .DIV(4), .DEPTH(4), .MSB_FIRST(0)) u_lsb (.clk(clk), .rst(rst), .bus(if1));
  serial_word_tx #(.WIDTH(8), .DIV(1), .DEPTH(4), .MSB_FIRST(1)) u_div1 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0][7:0] win;
  logic [2:0]      wv;
  logic [2:0]      rdy, ce, dout, bsy, st;
  logic [2:0][2:0] cnt;

  assign if0.word_in = win[0]; assign if0.word_valid = wv[0];
  assign if1.word_in = win[1]; assign if1.word_valid = wv[1];
  assign if2.word_in = win[2]; assign if2.word_valid = wv[2];
  assign rdy[0] = if0.word_ready; assign rdy[1] = if1.word_ready; assign rdy[2] = if2.word_ready;
  assign ce[0]  = if0.com_en;     assign ce[1]  = if1.com_en;     assign ce[2]  = if2.com_en;
  assign dout[0] = if0.dataout;   assign dout[1] = if1.dataout;   assign dout[2] = if2.dataout;
  assign bsy[0] = if0.busy;       assign bsy[1] = if1.busy;       assign bsy[2] = if2.busy;
  assign st[0]  = if0.state_dbg;  assign st[1]  = if1.state_dbg;  assign st[2]  = if2.state_dbg;
  assign cnt[0] = if0.fifo_count; assign cnt[1] = if1.fifo_count; assign cnt[2] = if2.fifo_count;

  // Entry: [15] = exactly one idle cycle must precede this frame; [8:1] = data bits in
  // transmit order (first bit in [8]); [0] = parity bit.
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  int          run_len[3];
  int          gap_len[3];
  logic [63:0] samp[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] ord, input logic par, input logic strict);
    logic [15:0] r;
    r = '0;
    r[15]  = strict;
    r[8:0] = {ord, par};
    return r;
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic exp_push(input int id, input logic [15:0] e);
    case (id)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic end_frame(input int id, input int div);
    logic [15:0] e;
    logic        got;
    logic [8:0]  act_f, exp_f, mask;
    logic        held;
    int          len;
    got = 1'b0;
    e   = '0;
    len = run_len[id];
    case (id)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL frame_unexpected inst=%0d actual_len=%0d required=none", id, len);
    end else begin
      check($sformatf("frame_len inst=%0d", id), len, NB * div);
      mask  = (NB == 9) ? 9'h1ff : 9'h1fe;
      act_f = '0;
      held  = 1'b1;
      if (len == NB * div) begin
        for (int k = 0; k < NB; k++) begin
          act_f[8-k] = samp[id][len-1-k*div];
          for (int s = 1; s < div; s++)
            if (samp[id][len-1-k*div-s] !== act_f[8-k]) held = 1'b0;
        end
      end
      exp_f = e[8:0] & mask;
      check($sformatf("frame_bits inst=%0d held,bits", id), {held, act_f & mask}, {1'b1, exp_f});
      if (e[15]) check($sformatf("frame_gap inst=%0d", id), gap_len[id], 1);
    end
  endtask

  task automatic mon(input int id, input int div, input logic c, input logic d);
    if (rst) begin
      run_len[id] = 0;
      gap_len[id] = 0;
    end else if (c) begin
      samp[id] = {samp[id][62:0], d};
      run_len[id]++;
    end else if (run_len[id] > 0) begin
      end_frame(id, div);
      run_len[id] = 0;
      gap_len[id] = 1;
    end else begin
      gap_len[id]++;
    end
  endtask

  always @(negedge clk) begin
    mon(0, 4, ce[0], dout[0]);
    mon(1, 4, ce[1], dout[1]);
    mon(2, 1, ce[2], dout[2]);
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one word until accepted; waited = edges taken including the accepting one.
  task automatic push_word(input int id, input logic [7:0] w, output int waited);
    logic r;
    r = 1'b0;
    win[id] = w;
    wv[id]  = 1'b1;
    waited  = 0;
    while (waited < 300) begin
      r = rdy[id];
      @(posedge clk);
      #1;
      waited++;
      if (r) break;
    end
    wv[id] = 1'b0;
    if (!r) begin
      checks++;
      failures++;
      $display("FAIL push_timeout inst=%0d actual=not accepted required=accepted", id);
    end
  endtask

  task automatic drain(input int id);
    int n;
    n = 0;
    while (n < 600 && (qsize(id) != 0 || bsy[id] || ce[id])) begin
      cyc(1);
      n++;
    end
    check($sformatf("drain inst=%0d pending", id), qsize(id), 0);
    cyc(2);
  endtask

  initial begin
    int w;
    int hi;
    int falls;
    logic pc;
    logic [7:0] burst_par;
    win = '0;
    wv  = '0;
    for (int i = 0; i < 3; i++) begin
      run_len[i] = 0; gap_len[i] = 0; samp[i] = '0;
    end

    // Reset state while rst is held
    #12;
    check("rst word_ready", rdy[0], 0);
    check("rst fifo_count", cnt[0], 0);
    check("rst com_en/dataout/busy/state", {ce[0], dout[0], bsy[0], st[0]}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready after release", rdy, 3'b111);

    // 0xA5 MSB-first, first-bit latency
    exp_push(0, mk(8'b10100101, 1'b0, 1'b0));
    push_word(0, 8'hA5, w);
    check("a5 post-push count,com_en,busy", {cnt[0], ce[0], bsy[0]}, {3'd1, 1'b0, 1'b1});
    cyc(1);
    check("a5 first bit com_en,dataout,count,state", {ce[0], dout[0], cnt[0], st[0]}, {1'b1, 1'b1, 3'd0, 1'b1});
    drain(0);

    // 0x1E LSB-first
    exp_push(1, mk(8'b01111000, 1'b0, 1'b0));
    push_word(1, 8'h1E, w);
    drain(1);

    // Burst of words 1..6 with valid held
    burst_par = 8'b0_001011_0;
    for (int k = 1; k <= 6; k++)
      exp_push(0, mk(8'(k), burst_par[k], k > 1));
    for (int k = 1; k <= 5; k++) begin
      push_word(0, 8'(k), w);
      wv[0] = 1'b1;
      check($sformatf("burst word%0d accept edges", k), w, 1);
    end
    check("burst full count,ready", {cnt[0], rdy[0]}, {3'd4, 1'b0});
    push_word(0, 8'd6, w);
    check("word6 stall edges", w, NB * 4 - 1);
    check("word6 count after accept", cnt[0], 4);
    drain(0);

    // Parity trailer words
    exp_push(0, mk(8'b00000111, 1'b1, 1'b0));
    exp_push(0, mk(8'b00000011, 1'b0, 1'b1));
    push_word(0, 8'h07, w);
    push_word(0, 8'h03, w);
    drain(0);
    exp_push(1, mk(8'b11100000, 1'b1, 1'b0));
    push_word(1, 8'h07, w);
    drain(1);

    // Reset in bit 3 of a frame with two words queued
    exp_push(0, mk(8'b00010001, 1'b0, 1'b0));
    push_word(0, 8'h11, w);
    push_word(0, 8'h22, w);
    push_word(0, 8'h33, w);
    cyc(12);
    check("pre-reset bit3 dataout,count", {dout[0], cnt[0]}, {1'b1, 3'd2});
    rst = 1'b1;
    #1;
    check("async reset com_en,dataout,busy,ready", {ce[0], dout[0], bsy[0], rdy[0]}, 4'b0000);
    check("async reset count", cnt[0], 0);
    exp_q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      if (ce[0]) hi++;
    end
    check("post-reset silent com_en cycles", hi, 0);
    check("post-reset busy,count", {bsy[0], cnt[0]}, 4'b0000);
    exp_push(0, mk(8'b01011010, 1'b0, 1'b0));
    push_word(0, 8'h5A, w);
    drain(0);

    // DIV=1: 0xFF then 0x00 back to back
    exp_push(2, mk(8'hFF, 1'b0, 1'b0));
    exp_push(2, mk(8'h00, 1'b0, 1'b1));
    push_word(2, 8'hFF, w);
    push_word(2, 8'h00, w);
    falls = 0;
    pc = ce[2];
    for (int i = 0; i < 100 && falls < 2; i++) begin
      cyc(1);
      if (pc && !ce[2]) falls++;
      pc = ce[2];
    end
    check("div1 frame ends seen", falls, 2);
    check("div1 busy,state after last bit", {bsy[2], st[2]}, 2'b00);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parametrised successor to the single-word serial sender in the exchange datapath.
- Accepts words over a valid/ready handshake into a small FIFO.
- Serialises each word onto a single data line, with a frame-enable strobe, at a programmable bit rate.
- Bit timing comes from a clock-enable counter in the clk domain; no derived clock.

Parameters:
- WIDTH, 32, data bits per frame (>=2).
- DIV, 50, clk cycles per serial bit (>=1).
- DEPTH, 4, FIFO depth in words (power of two, >=2).
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- word_in  in  WIDTH  word to transmit.
- word_valid  in  1  word_in valid.
- word_ready  out  1  FIFO can accept; registered, high when fifo_count < DEPTH.
- dataout  out  1  serial data bit.
- com_en  out  1  high for every cycle a frame bit is on dataout.
- busy  out  1  high when state is SHIFT or the FIFO is non-empty.
- fifo_count  out  clog2(DEPTH)+1  words currently queued.

Behaviour:
- Reset (async, rst=1) takes effect immediately:
  - FIFO emptied, fifo_count=0.
  - word_ready=0 while rst is high, then 1 from the first clk edge after release.
  - dataout=0, com_en=0, busy=0, state=IDLE, all counters=0.
  - Reset mid-frame aborts the frame; no partial resumption.
- Push: on an edge with word_valid && word_ready, word_in is written and fifo_count increments.
  - word_ready is based on the count before the edge. When full, a same-cycle pop does not let a push in.
- Simultaneous push and pop (not full): fifo_count unchanged; FIFO order preserved.
- FSM states: IDLE and SHIFT.
- IDLE:
  - com_en=0, dataout=0.
  - If the FIFO is non-empty at an edge: pop the head word into the shift register, go to SHIFT, load bit counter=0 and tick counter=0.
  - The registered dataout shows the first frame bit and com_en=1 from that same edge.
  - Latency: push at edge N into an empty idle block -> first bit and com_en=1 after edge N+1.
- SHIFT:
  - Each bit is held exactly DIV cycles; the tick counter runs 0..DIV-1.
  - At tick=DIV-1: advance to the next bit and reset tick to 0.
  - MSB_FIRST=1: order is bit WIDTH-1 down to bit 0. MSB_FIRST=0: order is bit 0 up to bit WIDTH-1.
  - Frame length NB = WIDTH bits (WIDTH+1 with parity); com_en stays high for NB*DIV consecutive cycles.
  - After the last bit's final tick: go to IDLE with com_en=0 and dataout=0.
- Inter-frame gap:
  - Every frame is followed by exactly one IDLE cycle before the next pop, so com_en is low for at least 1 cycle between frames.
  - Back-to-back frame period = NB*DIV + 1 cycles.
- DIV=1: one bit per clk; tick counter is unused and held at 0.
- Counter widths: clog2(DIV) bits for the tick counter, clog2(NB+1) bits for the bit counter. No wrap occurs inside a frame.
- FIFO pointers wrap modulo DEPTH; full = count==DEPTH; empty = count==0.

Optional Feature:
- Macro: SER_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all WIDTH data bits) follows the last data bit as bit NB-1, held DIV cycles with com_en high.
  - NB = WIDTH+1.
- Undefined: no parity logic; NB = WIDTH.
- Handshake and timing are otherwise identical.

Test Plan:
- WIDTH=8, DIV=4, MSB_FIRST=1; push 0xA5 -> dataout 1,0,1,0,0,1,0,1, each bit 4 cycles; com_en high 32 cycles, starting one edge after the push.
- MSB_FIRST=0; push 0x1E -> dataout 0,1,1,1,1,0,0,0; com_en high 32 cycles, then low.
- DEPTH=4; hold word_valid with words 1..6 on consecutive cycles:
  - word1 is popped at once; words 2-5 are queued (fifo_count=4); word_ready=0 stalls word6.
  - word6 is accepted the cycle after word2 is popped.
  - Frames appear in order, each separated by exactly 1 com_en-low cycle.
- Assert rst in bit 3 of a frame while 2 words are queued -> dataout=0, com_en=0, fifo_count=0 immediately. After release no frame is sent until a new push.
- DIV=1: push 0xFF then 0x00 -> 8 cycles of 1, one gap cycle, 8 cycles of 0; busy falls after the last bit.
- SER_TX_PARITY_EN defined: push 0x07 (WIDTH=8) -> 9-bit frame with parity bit 1, com_en high 36 cycles. Push 0x03 -> parity bit 0.
